freq_meter_bcd: RTL and testbench

FREQ_METER_BCD -- requirements
Module: freq_meter_bcd

---
 rtl/freq_meter_pkg.sv | 13 +
 rtl/bcd_digit_ctr.sv | 46 ++++
 rtl/freq_meter_bcd.sv | 127 ++++++++++++
 tb/tb_freq_meter_bcd.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants for the BCD frequency meter.
//   DEFAULT_GATE_CYCLES : clock cycles per measurement window (1 s at 50 MHz)
//   DEFAULT_NUM_DIGITS  : number of BCD digits in the result
//   BCD_DIGIT_W         : bits per BCD digit
//   BCD_MAX             : largest legal digit value
package freq_meter_pkg;

    localparam int unsigned DEFAULT_GATE_CYCLES = 50_000_000;
    localparam int unsigned DEFAULT_NUM_DIGITS  = 6;
    localparam int unsigned BCD_DIGIT_W         = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX  = 4'd9;

endpackage

// File: rtl/bcd_digit_ctr.sv
// One decade cell of the BCD edge counter.
//   clk_50MHz : system clock
//   reset_n   : synchronous active-low reset
//   inc       : advance this digit by one (9 wraps to 0)
//   clr       : force the digit to 0
//   load1     : force the digit to 1 (wins over clr)
//   digit     : current digit value, always 0-9
//   carry_out : inc while the digit is 9; drives the next cell's inc
module bcd_digit_ctr
    import freq_meter_pkg::*;
(
    input  logic                   clk_50MHz,
    input  logic                   reset_n,
    input  logic                   inc,
    input  logic                   clr,
    input  logic                   load1,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   carry_out
);

    logic [BCD_DIGIT_W-1:0] digit_q;
    logic [BCD_DIGIT_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load1) begin
            digit_d = BCD_DIGIT_W'(1);
        end else if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + BCD_DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit     = digit_q;
    assign carry_out = inc & (digit_q == BCD_MAX);

endmodule

// File: rtl/freq_meter_bcd.sv
// Gated frequency meter: counts rising edges of an asynchronous input over a
// window of GATE_CYCLES clocks directly in BCD and publishes the result.
//   clk_50MHz  : system clock, all logic on its rising edge
//   reset_n    : synchronous active-low reset
//   sig_in     : measured signal, asynchronous to clk_50MHz
//   run        : enables measurement; low holds timer and counter at 0
//   freq_bcd   : last completed window's edge count, digit 0 in [3:0]
//   meas_valid : one-cycle pulse when freq_bcd/overflow update
//   overflow   : last completed window exceeded the BCD range
module freq_meter_bcd
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int unsigned NUM_DIGITS  = DEFAULT_NUM_DIGITS
) (
    input  logic                              clk_50MHz,
    input  logic                              reset_n,
    input  logic                              sig_in,
    input  logic                              run,
    output logic [NUM_DIGITS*BCD_DIGIT_W-1:0] freq_bcd,
    output logic                              meas_valid,
    output logic                              overflow
);

    localparam int unsigned TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);

    // Two-flop synchronizer followed by an edge-detect delay flop.
    logic sync_meta_q;
    logic sync_q1;
    logic sync_q2;
    logic edge_tick;

    logic [TIMER_W-1:0] timer_q;
    logic               terminal;

    logic [NUM_DIGITS-1:0][BCD_DIGIT_W-1:0] cnt_digits;
    logic [NUM_DIGITS-1:0]                  inc;
    logic [NUM_DIGITS-1:0]                  carry;
    logic                                   all_nines;
    logic                                   count_en;
    logic                                   clr_all;
    logic                                   ovf_acc_q;
    logic                                   unused_top_carry;

    logic [NUM_DIGITS*BCD_DIGIT_W-1:0] freq_bcd_q;
    logic                              meas_valid_q;
    logic                              overflow_q;

    assign edge_tick = sync_q1 & ~sync_q2;
    assign terminal  = run & (timer_q == TIMER_LAST);

    always_comb begin
        all_nines = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (cnt_digits[i] != BCD_MAX) begin
                all_nines = 1'b0;
            end
        end
    end

    // The terminal-cycle edge belongs to the next window, and a full counter
    // saturates instead of wrapping.
    assign count_en = run & ~terminal & edge_tick & ~all_nines;
    assign clr_all  = ~run | terminal;

    for (genvar i = 0; i < int'(NUM_DIGITS); i++) begin : g_digit
        if (i == 0) begin : g_first
            assign inc[i] = count_en;
        end else begin : g_rest
            assign inc[i] = carry[i-1];
        end

        bcd_digit_ctr u_digit (
            .clk_50MHz (clk_50MHz),
            .reset_n   (reset_n),
            .inc       (inc[i]),
            .clr       (clr_all),
            .load1     ((i == 0) ? (terminal & edge_tick) : 1'b0),
            .digit     (cnt_digits[i]),
            .carry_out (carry[i])
        );
    end

    // Saturation gating keeps the top carry at 0; it has no consumer.
    assign unused_top_carry = carry[NUM_DIGITS-1];

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            sync_meta_q  <= 1'b0;
            sync_q1      <= 1'b0;
            sync_q2      <= 1'b0;
            timer_q      <= '0;
            ovf_acc_q    <= 1'b0;
            freq_bcd_q   <= '0;
            meas_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync_meta_q  <= sig_in;
            sync_q1      <= sync_meta_q;
            sync_q2      <= sync_q1;
            meas_valid_q <= terminal;

            if (clr_all) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TIMER_W'(1);
            end

            if (clr_all) begin
                ovf_acc_q <= 1'b0;
            end else if (edge_tick && all_nines) begin
                ovf_acc_q <= 1'b1;
            end

            if (terminal) begin
                freq_bcd_q <= cnt_digits;
                overflow_q <= ovf_acc_q;
            end
        end
    end

    assign freq_bcd   = freq_bcd_q;
    assign meas_valid = meas_valid_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_freq_meter_bcd.sv
// Directed bench for freq_meter_bcd with a 100-cycle gate: a 3-digit instance
// and a 1-digit instance share all inputs.
module tb_freq_meter_bcd;

    logic        clk_50MHz = 1'b0;
    logic        reset_n;
    logic        sig_in;
    logic        run;
    logic [11:0] freq3;
    logic        valid3;
    logic        ovf3;
    logic [3:0]  freq1;
    logic        valid1;
    logic        ovf1;

    int checks = 0;
    int errors = 0;

    // Results captured at the end of each run_window call.
    logic [11:0] w_freq3;
    logic        w_valid3;
    logic        w_ovf3;
    logic [3:0]  w_freq1;
    logic        w_valid1;
    logic        w_ovf1;
    int          w_stray;

    always #10 clk_50MHz = ~clk_50MHz;

    freq_meter_bcd #(
        .GATE_CYCLES (100),
        .NUM_DIGITS  (3)
    ) dut3 (
        .clk_50MHz  (clk_50MHz),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .run        (run),
        .freq_bcd   (freq3),
        .meas_valid (valid3),
        .overflow   (ovf3)
    );

    freq_meter_bcd #(
        .GATE_CYCLES (100),
        .NUM_DIGITS  (1)
    ) dut1 (
        .clk_50MHz  (clk_50MHz),
        .reset_n    (reset_n),
        .sig_in     (sig_in),
        .run        (run),
        .freq_bcd   (freq1),
        .meas_valid (valid1),
        .overflow   (ovf1)
    );

    // Called 1 ns after the edge that raised meas_valid (window boundary).
    // Drives one 100-cycle window; c counts edges from that boundary.
    // mode: 0 low, 1 high, 2 toggle each clk, 10 period-10, 4 pulses at 10/20/30/40.
    // extra >= 0 adds a 2-cycle pulse starting at c == extra.
    task automatic run_window(input int mode, input int extra);
        logic base;
        w_stray = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk_50MHz);
            #1;
            if (c < 100 && (valid3 || valid1)) w_stray++;
            case (mode)
                1:       base = 1'b1;
                2:       base = (c % 2) == 1;
                10:      base = (c % 10) < 5;
                4:       base = (c >= 10) && (c <= 41) && ((c % 10) <= 1);
                default: base = 1'b0;
            endcase
            sig_in = base | ((extra >= 0) && (c == extra || c == extra + 1));
        end
        w_freq3  = freq3;
        w_valid3 = valid3;
        w_ovf3   = ovf3;
        w_freq1  = freq1;
        w_valid1 = valid1;
        w_ovf1   = ovf1;
    endtask

    // Counts edges until meas_valid is seen 1 ns after an edge; -1 on timeout.
    task automatic wait_valid(input int budget, output int cycles);
        bit found = 1'b0;
        cycles = -1;
        for (int k = 1; k <= budget && !found; k++) begin
            @(posedge clk_50MHz);
            #1;
            if (valid3) begin
                cycles = k;
                found  = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        reset_n = 1'b0;
        run     = 1'b0;
        sig_in  = 1'b0;
        repeat (3) @(posedge clk_50MHz);
        #1;
        checks++;
        if ({freq3, ovf3, valid3, freq1, ovf1, valid1} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {freq3, ovf3, valid3, freq1, ovf1, valid1});
        end
        run = 1'b1;
        @(posedge clk_50MHz);
        #1;
        reset_n = 1'b1;
        wait_valid(300, cyc);
        checks++;
        if (cyc !== 100) begin
            errors++;
            $display("FAIL reset_first_window got %0d cycles want 100", cyc);
        end
        checks++;
        if (freq3 !== 12'h000 || valid1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_count got %h/%b want 000/1", freq3, valid1);
        end
    endtask

    task automatic test_period10();
        run_window(10, -1);
        for (int w = 0; w < 2; w++) begin
            run_window(10, -1);
            checks++;
            if (w_freq3 !== 12'h010 || w_ovf3 !== 1'b0 || w_valid3 !== 1'b1 || w_stray != 0) begin
                errors++;
                $display("FAIL p10_window got freq=%h ovf=%b valid=%b stray=%0d want 010/0/1/0",
                         w_freq3, w_ovf3, w_valid3, w_stray);
            end
            checks++;
            if (w_freq1 !== 4'h9 || w_ovf1 !== 1'b1 || w_valid1 !== 1'b1) begin
                errors++;
                $display("FAIL p10_one_digit got freq=%h ovf=%b valid=%b want 9/1/1",
                         w_freq1, w_ovf1, w_valid1);
            end
        end
    endtask

    task automatic test_period2();
        run_window(2, -1);
        run_window(2, -1);
        checks++;
        if (w_freq3 !== 12'h050 || w_ovf3 !== 1'b0) begin
            errors++;
            $display("FAIL p2_freq got %h ovf=%b want 050/0", w_freq3, w_ovf3);
        end
        checks++;
        if (w_freq1 !== 4'h9 || w_ovf1 !== 1'b1) begin
            errors++;
            $display("FAIL p2_saturate got %h ovf=%b want 9/1", w_freq1, w_ovf1);
        end
        // Rises at c=97 (terminal) and c=99 land in the following window.
        run_window(0, -1);
        checks++;
        if (w_freq3 !== 12'h002 || w_freq1 !== 4'h2 || w_ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL p2_spill got %h/%h ovf=%b want 002/2/0", w_freq3, w_freq1, w_ovf1);
        end
        run_window(0, -1);
        checks++;
        if (w_freq3 !== 12'h000 || w_ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL p2_quiet got %h ovf=%b want 000/0", w_freq3, w_ovf1);
        end
    endtask

    task automatic test_constant();
        run_window(1, -1);
        run_window(1, -1);
        checks++;
        if (w_freq3 !== 12'h000 || w_valid3 !== 1'b1) begin
            errors++;
            $display("FAIL const_high got %h valid=%b want 000/1", w_freq3, w_valid3);
        end
        run_window(0, -1);
        checks++;
        if (w_freq3 !== 12'h000 || w_stray != 0) begin
            errors++;
            $display("FAIL const_low got %h stray=%0d want 000/0", w_freq3, w_stray);
        end
    endtask

    task automatic test_terminal_edge();
        run_window(4, 97);
        checks++;
        if (w_freq3 !== 12'h004) begin
            errors++;
            $display("FAIL term_closing got %h want 004", w_freq3);
        end
        run_window(4, -1);
        checks++;
        if (w_freq3 !== 12'h005 || w_freq1 !== 4'h5) begin
            errors++;
            $display("FAIL term_next got %h/%h want 005/5", w_freq3, w_freq1);
        end
        run_window(4, 96);
        checks++;
        if (w_freq3 !== 12'h005) begin
            errors++;
            $display("FAIL term_minus1 got %h want 005", w_freq3);
        end
        run_window(4, -1);
        checks++;
        if (w_freq3 !== 12'h004) begin
            errors++;
            $display("FAIL term_after got %h want 004", w_freq3);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        sig_in = 1'b0;
        repeat (57) @(posedge clk_50MHz);
        #1;
        reset_n = 1'b0;
        @(posedge clk_50MHz);
        #1;
        checks++;
        if ({freq3, ovf3, valid3, freq1, ovf1, valid1} !== 18'h0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0",
                     {freq3, ovf3, valid3, freq1, ovf1, valid1});
        end
        reset_n = 1'b1;
        wait_valid(300, cyc);
        checks++;
        if (cyc !== 100 || freq3 !== 12'h000) begin
            errors++;
            $display("FAIL midreset_next got %0d cycles freq=%h want 100/000", cyc, freq3);
        end
    endtask

    task automatic test_run_abort();
        int cyc;
        int stray = 0;
        int held_bad = 0;
        run_window(10, -1);
        run_window(10, -1);
        checks++;
        if (w_freq3 !== 12'h010) begin
            errors++;
            $display("FAIL abort_prior got %h want 010", w_freq3);
        end
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_50MHz);
            #1;
            if (valid3) stray++;
            sig_in = (c % 10) < 5;
        end
        run = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk_50MHz);
            #1;
            sig_in = 1'b0;
            if (valid3) stray++;
            if (freq3 !== 12'h010) held_bad++;
        end
        checks++;
        if (stray != 0 || held_bad != 0) begin
            errors++;
            $display("FAIL abort_hold got stray=%0d held_bad=%0d want 0/0", stray, held_bad);
        end
        run = 1'b1;
        wait_valid(300, cyc);
        checks++;
        if (cyc !== 100) begin
            errors++;
            $display("FAIL abort_restart got %0d cycles want 100", cyc);
        end
        checks++;
        if (freq3 !== 12'h000 || freq1 !== 4'h0 || ovf1 !== 1'b0) begin
            errors++;
            $display("FAIL abort_discard got %h/%h ovf=%b want 000/0/0", freq3, freq1, ovf1);
        end
    endtask

    initial begin
        test_reset();
        test_period10();
        test_period2();
        test_constant();
        test_terminal_edge();
        test_reset_mid();
        test_run_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
